// File: rtl/z80_bus_arbiter.sv
// Shares one memory port between the tv80s CPU and a DMA burst engine via BUSRQ/BUSAK.
// Define Z80ARB_TIMEOUT_EN to add a REQ-state watchdog that aborts with a dma_err pulse.
module z80_bus_arbiter #(
   parameter int MAX_BURST      = 16,
   parameter int CPU_SLOT       = 4,
   parameter int TIMEOUT_CYCLES = 64,
   parameter int LW             = $clog2(MAX_BURST) + 1
) (
   input  logic          clk,
   input  logic          reset,
   output logic          cpu_busrq_n,
   input  logic          cpu_busak_n,
   input  logic [15:0]   cpu_a,
   input  logic [7:0]    cpu_do,
   input  logic          cpu_mreq_n,
   input  logic          cpu_wr_n,
   input  logic          dma_req,
   input  logic          dma_we,
   input  logic [15:0]   dma_addr,
   input  logic [LW-1:0] dma_len,
   input  logic [7:0]    dma_wdata,
   output logic          dma_beat,
   output logic [7:0]    dma_rdata,
   output logic          dma_rvalid,
   output logic          dma_done,
   output logic          dma_err,
   output logic [15:0]   mem_a,
   output logic [7:0]    mem_wdata,
   output logic          mem_we,
   input  logic [7:0]    mem_rdata
);

   localparam int            SW        = (CPU_SLOT < 1) ? 1 : $clog2(CPU_SLOT + 1);
   localparam logic [SW-1:0] SLOT_LOAD = SW'(CPU_SLOT);

   typedef enum logic [1:0] {
      ST_CPU,
      ST_REQ,
      ST_OWN,
      ST_REL
   } state_t;

   state_t        state_q, state_d;
   logic [15:0]   addr_q, addr_d;
   logic [LW-1:0] len_q, len_d;
   logic [LW-1:0] cnt_q, cnt_d;
   logic          we_q, we_d;
   logic [SW-1:0] slot_q, slot_d;
   logic          done_q, done_d;
   logic          rvalid_q, rvalid_d;
   logic [LW-1:0] len_clamped;

`ifdef Z80ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] to_q, to_d;
   logic          err_q, err_d;
`endif

   // Zero-length requests still move one byte; oversize requests are cut to one grant.
   always_comb begin
      len_clamped = dma_len;
      if (dma_len == '0) begin
         len_clamped = LW'(1);
      end else if (dma_len > LW'(MAX_BURST)) begin
         len_clamped = LW'(MAX_BURST);
      end
   end

   // NOTE: every output of this block gets a default before the case, so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      len_d       = len_q;
      we_d        = we_q;
      cnt_d       = cnt_q;
      slot_d      = slot_q;
      done_d      = 1'b0;
      rvalid_d    = 1'b0;
      cpu_busrq_n = 1'b1;
      dma_beat    = 1'b0;
      mem_a       = cpu_a;
      mem_wdata   = cpu_do;
      mem_we      = ~cpu_mreq_n & ~cpu_wr_n;
`ifdef Z80ARB_TIMEOUT_EN
      to_d        = '0;
      err_d       = 1'b0;
`endif

      unique case (state_q)
         ST_CPU: begin
            if (slot_q != '0) begin
               slot_d = slot_q - SW'(1);
            end else if (dma_req) begin
               addr_d  = dma_addr;
               len_d   = len_clamped;
               we_d    = dma_we;
               state_d = ST_REQ;
            end
         end

         // The CPU finishes its current M-cycle before acknowledging, so its strobes still pass.
         ST_REQ: begin
            cpu_busrq_n = 1'b0;
`ifdef Z80ARB_TIMEOUT_EN
            to_d = to_q + TW'(1);
`endif
            if (!cpu_busak_n) begin
               state_d = ST_OWN;
               cnt_d   = '0;
            end
`ifdef Z80ARB_TIMEOUT_EN
            else if (to_q == TW'(TIMEOUT_CYCLES - 1)) begin
               state_d = ST_CPU;
               slot_d  = SLOT_LOAD;
               err_d   = 1'b1;
            end
`endif
         end

         ST_OWN: begin
            cpu_busrq_n = 1'b0;
            dma_beat    = 1'b1;
            mem_a       = addr_q;
            mem_wdata   = dma_wdata;
            mem_we      = we_q;
            addr_d      = addr_q + 16'd1;
            cnt_d       = cnt_q + LW'(1);
            rvalid_d    = ~we_q;
            if (cnt_q == len_q - LW'(1)) begin
               state_d = ST_REL;
               done_d  = 1'b1;
            end
         end

         // Park on the DMA address until the CPU drops BUSAK, so no stray CPU cycle slips in early.
         ST_REL: begin
            mem_a     = addr_q;
            mem_wdata = dma_wdata;
            mem_we    = 1'b0;
            if (cpu_busak_n) begin
               state_d = ST_CPU;
               slot_d  = SLOT_LOAD;
            end
         end

         default: state_d = ST_CPU;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_CPU;
         slot_q   <= '0;
         done_q   <= 1'b0;
         rvalid_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         slot_q   <= slot_d;
         done_q   <= done_d;
         rvalid_q <= rvalid_d;
      end
   end

   // NOTE: the burst datapath is left unreset; it is always loaded before any state reads it.
   always_ff @(posedge clk) begin
      addr_q <= addr_d;
      len_q  <= len_d;
      we_q   <= we_d;
      cnt_q  <= cnt_d;
   end

`ifdef Z80ARB_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         to_q  <= '0;
         err_q <= 1'b0;
      end else begin
         to_q  <= to_d;
         err_q <= err_d;
      end
   end

   assign dma_err = err_q;
`else
   assign dma_err = 1'b0;
`endif

   // The memory delivers read data one cycle after the beat; present it while rvalid is high.
   assign dma_rvalid = rvalid_q;
   assign dma_rdata  = rvalid_q ? mem_rdata : 8'h00;
   assign dma_done   = done_q;

endmodule

// File: tb/tb_z80_bus_arbiter.sv
// Scoreboard bench for z80_bus_arbiter: a memory/CPU model, directed bursts, and a negedge monitor.
module tb_z80_bus_arbiter;

   localparam int LW = 5;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          cpu_busrq_n;
   logic          cpu_busak_n;
   logic [15:0]   cpu_a;
   logic [7:0]    cpu_do;
   logic          cpu_mreq_n;
   logic          cpu_wr_n;
   logic          dma_req;
   logic          dma_we;
   logic [15:0]   dma_addr;
   logic [LW-1:0] dma_len;
   logic [7:0]    dma_wdata;
   logic          dma_beat;
   logic [7:0]    dma_rdata;
   logic          dma_rvalid;
   logic          dma_done;
   logic          dma_err;
   logic [15:0]   mem_a;
   logic [7:0]    mem_wdata;
   logic          mem_we;
   logic [7:0]    mem_rdata;

   z80_bus_arbiter dut (
      .clk         (clk),
      .reset       (reset),
      .cpu_busrq_n (cpu_busrq_n),
      .cpu_busak_n (cpu_busak_n),
      .cpu_a       (cpu_a),
      .cpu_do      (cpu_do),
      .cpu_mreq_n  (cpu_mreq_n),
      .cpu_wr_n    (cpu_wr_n),
      .dma_req     (dma_req),
      .dma_we      (dma_we),
      .dma_addr    (dma_addr),
      .dma_len     (dma_len),
      .dma_wdata   (dma_wdata),
      .dma_beat    (dma_beat),
      .dma_rdata   (dma_rdata),
      .dma_rvalid  (dma_rvalid),
      .dma_done    (dma_done),
      .dma_err     (dma_err),
      .mem_a       (mem_a),
      .mem_wdata   (mem_wdata),
      .mem_we      (mem_we),
      .mem_rdata   (mem_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] a;
      logic [7:0]  d;
   } wr_t;

   typedef struct {
      int   beats;
      logic rv;
   } done_t;

   wr_t   exp_wr[$];
   logic [7:0] exp_rd[$];
   done_t exp_done[$];
   int    exp_err[$];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int done_seen = 0;
   int err_seen  = 0;
   int falls_seen = 0;
   int mon_beats = 0;
   int t_busak_rise = 0;
   int t_busrq_fall = 0;
   int t_err = 0;

   logic [7:0] mem [65536];
   logic [7:0] wbuf [256];
   logic [7:0] beat_idx = 8'd0;
   logic [1:0] rq_sr = 2'b11;
   logic       ack_block = 1'b0;

   // Memory with one-cycle synchronous read; CPU acknowledges BUSRQ two cycles late.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_we) mem[mem_a] <= mem_wdata;
      mem_rdata <= mem[mem_a];
      rq_sr <= {rq_sr[0], cpu_busrq_n};
      if (dma_beat) beat_idx <= beat_idx + 8'd1;
   end

   assign cpu_busak_n = ack_block | rq_sr[1];
   assign dma_wdata   = wbuf[beat_idx];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic unexpected(input string name);
      total++;
      bad++;
      $display("FAIL %s: got unexpected event expected none (cycle %0d)", name, cyc);
   endtask

   // Monitor: pops expectations whenever the DUT presents a write, read data, done or error.
   initial begin
      wr_t   w;
      done_t dn;
      logic  prev_busak = 1'b1;
      logic  prev_busrq = 1'b1;
      forever begin
         @(negedge clk);
         if (mem_we) begin
            if (exp_wr.size() == 0) unexpected("mem_write");
            else begin
               w = exp_wr.pop_front();
               check("wr_addr", 32'(mem_a), 32'(w.a));
               check("wr_data", 32'(mem_wdata), 32'(w.d));
            end
         end
         if (dma_beat) mon_beats++;
         if (dma_rvalid) begin
            if (exp_rd.size() == 0) unexpected("dma_rvalid");
            else check("rd_data", 32'(dma_rdata), 32'(exp_rd.pop_front()));
         end
         if (dma_done) begin
            if (exp_done.size() == 0) unexpected("dma_done");
            else begin
               dn = exp_done.pop_front();
               check("burst_beats", 32'(mon_beats), 32'(dn.beats));
               check("rvalid_with_done", 32'(dma_rvalid), 32'(dn.rv));
            end
            mon_beats = 0;
            done_seen++;
         end
         if (dma_err) begin
            if (exp_err.size() == 0) unexpected("dma_err");
            else void'(exp_err.pop_front());
            err_seen++;
            t_err = cyc;
         end
         if (reset) mon_beats = 0;
         if (cpu_busak_n && !prev_busak) t_busak_rise = cyc;
         if (!cpu_busrq_n && prev_busrq) begin
            t_busrq_fall = cyc;
            falls_seen++;
         end
         prev_busak = cpu_busak_n;
         prev_busrq = cpu_busrq_n;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_wr(input logic [15:0] a, input logic [7:0] d);
      wr_t w;
      w.a = a;
      w.d = d;
      exp_wr.push_back(w);
   endtask

   task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
      push_wr(a, d);
      step();
      cpu_a = a; cpu_do = d; cpu_mreq_n = 1'b0; cpu_wr_n = 1'b0;
      step();
      cpu_mreq_n = 1'b1; cpu_wr_n = 1'b1;
   endtask

   task automatic wait_done(input int target);
      int n = 0;
      while (done_seen < target && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("done_within_bound", 32'(done_seen >= target), 32'd1);
   endtask

   task automatic run_burst(input logic we, input logic [15:0] addr, input logic [LW-1:0] len,
                            input int beats, input logic [7:0] d0, input logic [7:0] dstep);
      done_t dn;
      int    target;
      dn.beats = beats;
      dn.rv    = ~we;
      exp_done.push_back(dn);
      for (int i = 0; i < beats; i++) wbuf[beat_idx + 8'(i)] = d0 + 8'(i) * dstep;
      target = done_seen + 1;
      step();
      dma_req = 1'b1; dma_we = we; dma_addr = addr; dma_len = len;
      @(negedge clk);
      check("busrq_before_grant", 32'(cpu_busrq_n), 32'd1);
      step();
      dma_req = 1'b0;
      @(negedge clk);
      check("busrq_asserted", 32'(cpu_busrq_n), 32'd0);
      wait_done(target);
      repeat (12) step();
   endtask

   initial begin
      int  gap;
      int  target;
      int  base;
      logic found;
      dma_req = 1'b0; dma_we = 1'b0; dma_addr = 16'h0000; dma_len = '0;
      cpu_a = 16'h0000; cpu_do = 8'h00; cpu_mreq_n = 1'b1; cpu_wr_n = 1'b1;
      for (int i = 0; i < 256; i++) wbuf[i] = 8'h00;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_busrq_n", 32'(cpu_busrq_n), 32'd1);
      check("rst_beat", 32'(dma_beat), 32'd0);
      check("rst_rvalid", 32'(dma_rvalid), 32'd0);
      check("rst_done", 32'(dma_done), 32'd0);
      check("rst_err", 32'(dma_err), 32'd0);
      check("rst_rdata", 32'(dma_rdata), 32'h00);
      step();
      reset = 1'b0;
      repeat (3) step();

      // CPU pass-through writes also preload the read-wrap and reset-test locations
      cpu_write(16'hFFFF, 8'h11);
      cpu_write(16'h0000, 8'h22);
      cpu_write(16'h2002, 8'hEE);

      // Write burst AA/BB/CC at 4FF2
      push_wr(16'h4FF2, 8'hAA);
      push_wr(16'h4FF3, 8'hBB);
      push_wr(16'h4FF4, 8'hCC);
      run_burst(1'b1, 16'h4FF2, 5'd3, 3, 8'hAA, 8'h11);
      check("mem_4ff2", 32'(mem[16'h4FF2]), 32'h0AA);
      check("mem_4ff3", 32'(mem[16'h4FF3]), 32'h0BB);
      check("mem_4ff4", 32'(mem[16'h4FF4]), 32'h0CC);
      check("busrq_released", 32'(cpu_busrq_n), 32'd1);

      // Read burst wrapping FFFF -> 0000
      exp_rd.push_back(8'h11);
      exp_rd.push_back(8'h22);
      run_burst(1'b0, 16'hFFFF, 5'd2, 2, 8'h00, 8'h00);

      // Length 0 gives one beat; length 31 clamps to 16
      push_wr(16'h3000, 8'h60);
      run_burst(1'b1, 16'h3000, 5'd0, 1, 8'h60, 8'h00);
      for (int i = 0; i < 16; i++) push_wr(16'h3100 + 16'(i), 8'h70 + 8'(i));
      run_burst(1'b1, 16'h3100, 5'd31, 16, 8'h70, 8'h01);
      check("mem_3110_untouched", 32'(mem[16'h3110]), 32'h00);

      // Back-to-back requests with dma_req held high
      begin
         done_t dn;
         dn.beats = 1;
         dn.rv    = 1'b0;
         exp_done.push_back(dn);
         exp_done.push_back(dn);
      end
      push_wr(16'h5000, 8'h81);
      push_wr(16'h5010, 8'h82);
      wbuf[beat_idx]        = 8'h81;
      wbuf[beat_idx + 8'd1] = 8'h82;
      base   = falls_seen;
      target = done_seen + 2;
      step();
      dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h5000; dma_len = 5'd1;
      step();
      dma_addr = 16'h5010;
      for (int n = 0; n < 100 && falls_seen < base + 2; n++) @(negedge clk);
      check("b2b_second_request", 32'(falls_seen), 32'(base + 2));
      step();
      dma_req = 1'b0;
      gap = t_busrq_fall - t_busak_rise;
      check("b2b_gap_min_slot", 32'(gap >= 4), 32'd1);
      check("b2b_gap_bounded", 32'(gap <= 12), 32'd1);
      wait_done(target);
      repeat (12) step();

      // Reset on beat 2 of a 5-beat write
      push_wr(16'h2000, 8'h51);
      push_wr(16'h2001, 8'h52);
      for (int i = 0; i < 5; i++) wbuf[beat_idx + 8'(i)] = 8'h51 + 8'(i);
      step();
      dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h2000; dma_len = 5'd5;
      step();
      dma_req = 1'b0;
      found = 1'b0;
      for (int n = 0; n < 50 && !found; n++) begin
         step();
         if (dma_beat && mon_beats == 1) found = 1'b1;
      end
      check("reset_beat2_reached", 32'(found), 32'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("reset_busrq_n", 32'(cpu_busrq_n), 32'd1);
      check("reset_beat_off", 32'(dma_beat), 32'd0);
      repeat (12) step();
      check("reset_mem_2000", 32'(mem[16'h2000]), 32'h51);
      check("reset_mem_2001", 32'(mem[16'h2001]), 32'h52);
      check("reset_mem_2002", 32'(mem[16'h2002]), 32'hEE);

      // Request with BUSAK held inactive; CPU traffic in REQ still reaches memory
      ack_block = 1'b1;
      wbuf[beat_idx] = 8'h99;
      step();
      dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h4000; dma_len = 5'd1;
      step();
      dma_req = 1'b0;
      repeat (4) step();
      cpu_write(16'h4100, 8'h3C);
`ifdef Z80ARB_TIMEOUT_EN
      exp_err.push_back(1);
      repeat (75) step();
      check("timeout_err_seen", 32'(err_seen), 32'd1);
      check("timeout_err_delay", 32'(t_err - t_busrq_fall), 32'd64);
      check("timeout_busrq_n", 32'(cpu_busrq_n), 32'd1);
      ack_block = 1'b0;
      repeat (12) step();
      check("timeout_no_write", 32'(mem[16'h4000]), 32'h00);
`else
      repeat (75) step();
      check("no_timeout_busrq_n", 32'(cpu_busrq_n), 32'd0);
      check("no_timeout_err", 32'(err_seen), 32'd0);
      check("no_timeout_no_write", 32'(mem[16'h4000]), 32'h00);
      begin
         done_t dn;
         dn.beats = 1;
         dn.rv    = 1'b0;
         exp_done.push_back(dn);
      end
      push_wr(16'h4000, 8'h99);
      target = done_seen + 1;
      ack_block = 1'b0;
      wait_done(target);
      repeat (12) step();
`endif
      check("mem_4100_cpu_in_req", 32'(mem[16'h4100]), 32'h3C);

      check("exp_wr_drained", 32'(exp_wr.size()), 32'd0);
      check("exp_rd_drained", 32'(exp_rd.size()), 32'd0);
      check("exp_done_drained", 32'(exp_done.size()), 32'd0);
      check("exp_err_drained", 32'(exp_err.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
